// File: rtl/stage_ex_pkg.sv
// rtl/stage_ex_pkg.sv - shared operator/category codes and divider state for the EX stage
// Purpose: constants shared by stage_id, stage_ex and stage_mem, plus the divider
//          state type and a conditional two's-complement helper.
package stage_ex_pkg;

  // Operation classes produced by decode
  localparam logic [2:0] CAT_NOP    = 3'b000;
  localparam logic [2:0] CAT_LOGIC  = 3'b001;
  localparam logic [2:0] CAT_SHIFT  = 3'b010;
  localparam logic [2:0] CAT_MOVE   = 3'b011;
  localparam logic [2:0] CAT_ARITH  = 3'b100;
  localparam logic [2:0] CAT_MULDIV = 3'b101;

  // Logic
  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  // Shift
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  // Move
  localparam logic [7:0] OP_MFHI = 8'b00010000;
  localparam logic [7:0] OP_MTHI = 8'b00010001;
  localparam logic [7:0] OP_MFLO = 8'b00010010;
  localparam logic [7:0] OP_MTLO = 8'b00010011;
  // Arithmetic
  localparam logic [7:0] OP_ADD  = 8'b00100000;
  localparam logic [7:0] OP_ADDU = 8'b00100001;
  localparam logic [7:0] OP_SUB  = 8'b00100010;
  localparam logic [7:0] OP_SUBU = 8'b00100011;
  localparam logic [7:0] OP_SLT  = 8'b00101010;
  localparam logic [7:0] OP_SLTU = 8'b00101011;
  // Multiply / divide
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Two's-complement negate when requested; used for both magnitude and sign restore
  function automatic logic [31:0] negate_if(input logic [31:0] value, input logic negate);
    return negate ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/stage_ex_if.sv
// rtl/stage_ex_if.sv - ID/EX inputs, hilo forwarding and EX results as one bundle
// Purpose: groups every non-clock/reset signal of stage_ex.
// Ports (slave view): operator, category, operand_a, operand_b,
//   register_write_enable_in, register_write_address_in, hi, lo,
//   mem_hilo_write_enable, mem_hi, mem_lo, wb_hilo_write_enable, wb_hi, wb_lo (in);
//   register_write_enable, register_write_address, register_write_data,
//   hilo_write_enable, hi_write_data, lo_write_data, stall_request (out).
interface stage_ex_if;
  logic [7:0]  operator;
  logic [2:0]  category;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        register_write_enable_in;
  logic [4:0]  register_write_address_in;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mem_hilo_write_enable;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        wb_hilo_write_enable;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        register_write_enable;
  logic [4:0]  register_write_address;
  logic [31:0] register_write_data;
  logic        hilo_write_enable;
  logic [31:0] hi_write_data;
  logic [31:0] lo_write_data;
  logic        stall_request;

  modport master (
    output operator, category, operand_a, operand_b,
           register_write_enable_in, register_write_address_in, hi, lo,
           mem_hilo_write_enable, mem_hi, mem_lo,
           wb_hilo_write_enable, wb_hi, wb_lo,
    input  register_write_enable, register_write_address, register_write_data,
           hilo_write_enable, hi_write_data, lo_write_data, stall_request
  );

  modport slave (
    input  operator, category, operand_a, operand_b,
           register_write_enable_in, register_write_address_in, hi, lo,
           mem_hilo_write_enable, mem_hi, mem_lo,
           wb_hilo_write_enable, wb_hi, wb_lo,
    output register_write_enable, register_write_address, register_write_data,
           hilo_write_enable, hi_write_data, lo_write_data, stall_request
  );
endinterface

// File: rtl/stage_ex_divider.sv
// rtl/stage_ex_divider.sv - 32-bit restoring divider, one quotient bit per cycle
// Purpose: iterative signed/unsigned divide for DIV/DIVU.
// Ports: clock, reset (sync, active-high), start, is_signed, dividend, divisor (in);
//        result[63:32]=remainder, result[31:0]=quotient, ready (one-cycle pulse in DONE) (out).
module stage_ex_divider
  import stage_ex_pkg::*;
#(
  parameter int DIVIDE_STEPS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [63:0] result,
  output logic        ready
);

  div_state_e  state;
  logic [4:0]  counter;
  logic [31:0] rem;
  logic [31:0] quo;   // shifts the dividend out and the quotient in
  logic [31:0] den;
  logic        neg_quotient;
  logic        neg_remainder;

  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  always_comb begin
    shifted  = {rem, quo[31]};
    fits     = shifted >= {1'b0, den};
    rem_next = fits ? 32'(shifted - {1'b0, den}) : shifted[31:0];
    quo_next = {quo[30:0], fits};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= DIV_IDLE;
      counter       <= '0;
      rem           <= '0;
      quo           <= '0;
      den           <= '0;
      neg_quotient  <= 1'b0;
      neg_remainder <= 1'b0;
      result        <= '0;
      ready         <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          ready <= 1'b0;
          if (start) begin
            if (divisor == 32'd0) begin
              result <= '0;
              ready  <= 1'b1;
              state  <= DIV_DONE;
            end else begin
              quo           <= negate_if(dividend, is_signed & dividend[31]);
              den           <= negate_if(divisor, is_signed & divisor[31]);
              rem           <= '0;
              counter       <= '0;
              neg_quotient  <= is_signed & (dividend[31] ^ divisor[31]);
              neg_remainder <= is_signed & dividend[31];
              state         <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          rem     <= rem_next;
          quo     <= quo_next;
          counter <= counter + 5'd1;
          if (counter == 5'(DIVIDE_STEPS - 1)) begin
            result <= {negate_if(rem_next, neg_remainder), negate_if(quo_next, neg_quotient)};
            ready  <= 1'b1;
            state  <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          // DIV is still presented here; returning to IDLE without looking at start
          ready <= 1'b0;
          state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stage_ex.sv
// rtl/stage_ex.sv - MIPS execute stage: ALU, shifter, HI/LO moves, multiply, divide
// Purpose: single-cycle combinational results for all ops except DIV/DIVU, which
//          use the iterative divider and hold the front of the pipe via stall_request.
// Ports: clock, reset (sync, active-high); bus (stage_ex_if.slave) carrying decode
//        inputs, HI/LO forwarding inputs and the GPR/HILO writeback outputs.
module stage_ex
  import stage_ex_pkg::*;
#(
  parameter int DIVIDE_STEPS = 32
) (
  input logic        clock,
  input logic        reset,
  stage_ex_if.slave  bus
);

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] eff_hi;
  logic [31:0] eff_lo;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_start;
  logic        div_ready;
  logic [63:0] div_result;

  assign a = bus.operand_a;
  assign b = bus.operand_b;

  // Newest HI/LO wins: MEM is younger than WB, WB younger than the register file
  assign eff_hi = bus.mem_hilo_write_enable ? bus.mem_hi :
                  bus.wb_hilo_write_enable  ? bus.wb_hi  : bus.hi;
  assign eff_lo = bus.mem_hilo_write_enable ? bus.mem_lo :
                  bus.wb_hilo_write_enable  ? bus.wb_lo  : bus.lo;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

  // Low 64 bits of a 64x64 product equal the full 32x32 product
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign div_start = (bus.category == CAT_MULDIV) &&
                     ((bus.operator == OP_DIV) || (bus.operator == OP_DIVU));

  stage_ex_divider #(.DIVIDE_STEPS(DIVIDE_STEPS)) u_divider (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .is_signed(bus.operator == OP_DIV),
    .dividend (a),
    .divisor  (b),
    .result   (div_result),
    .ready    (div_ready)
  );

  always_comb begin
    bus.register_write_enable  = 1'b0;
    bus.register_write_address = 5'd0;
    bus.register_write_data    = 32'd0;
    bus.hilo_write_enable      = 1'b0;
    bus.hi_write_data          = 32'd0;
    bus.lo_write_data          = 32'd0;
    bus.stall_request          = 1'b0;
    if (!reset) begin
      bus.register_write_address = bus.register_write_address_in;
      // ready marks the DONE cycle, the only divide cycle that does not stall
      bus.stall_request = div_start && !div_ready;
      // Unknown operators leave the write enables at 0
      case (bus.category)
        CAT_NOP: bus.register_write_enable = bus.register_write_enable_in;
        CAT_LOGIC: begin
          bus.register_write_enable = bus.register_write_enable_in;
          case (bus.operator)
            OP_AND:  bus.register_write_data = a & b;
            OP_OR:   bus.register_write_data = a | b;
            OP_XOR:  bus.register_write_data = a ^ b;
            OP_NOR:  bus.register_write_data = ~(a | b);
            default: bus.register_write_enable = 1'b0;
          endcase
        end
        CAT_SHIFT: begin
          bus.register_write_enable = bus.register_write_enable_in;
          case (bus.operator)
            OP_SLL:  bus.register_write_data = b << a[4:0];
            OP_SRL:  bus.register_write_data = b >> a[4:0];
            OP_SRA:  bus.register_write_data = $signed(b) >>> a[4:0];
            default: bus.register_write_enable = 1'b0;
          endcase
        end
        CAT_MOVE: begin
          bus.register_write_enable = bus.register_write_enable_in;
          case (bus.operator)
            OP_MFHI: bus.register_write_data = eff_hi;
            OP_MFLO: bus.register_write_data = eff_lo;
            OP_MTHI: begin
              bus.hilo_write_enable = 1'b1;
              bus.hi_write_data     = a;
              bus.lo_write_data     = eff_lo;
            end
            OP_MTLO: begin
              bus.hilo_write_enable = 1'b1;
              bus.hi_write_data     = eff_hi;
              bus.lo_write_data     = a;
            end
            default: bus.register_write_enable = 1'b0;
          endcase
        end
        CAT_ARITH: begin
          bus.register_write_enable = bus.register_write_enable_in;
          case (bus.operator)
            OP_ADD: begin
              bus.register_write_data   = sum;
              bus.register_write_enable = bus.register_write_enable_in & ~add_ovf;
            end
            OP_ADDU: bus.register_write_data = sum;
            OP_SUB: begin
              bus.register_write_data   = diff;
              bus.register_write_enable = bus.register_write_enable_in & ~sub_ovf;
            end
            OP_SUBU: bus.register_write_data = diff;
            OP_SLT:  bus.register_write_data = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: bus.register_write_data = {31'd0, a < b};
            default: bus.register_write_enable = 1'b0;
          endcase
        end
        CAT_MULDIV: begin
          case (bus.operator)
            OP_MULT: begin
              bus.hilo_write_enable = 1'b1;
              bus.hi_write_data     = prod_s[63:32];
              bus.lo_write_data     = prod_s[31:0];
            end
            OP_MULTU: begin
              bus.hilo_write_enable = 1'b1;
              bus.hi_write_data     = prod_u[63:32];
              bus.lo_write_data     = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
              bus.hilo_write_enable = div_ready;
              if (div_ready) begin
                bus.hi_write_data = div_result[63:32];
                bus.lo_write_data = div_result[31:0];
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ex.sv
// tb/tb_stage_ex.sv - self-checking bench for stage_ex against a behavioural model
module tb_stage_ex;
  import stage_ex_pkg::*;

  typedef struct {
    logic [2:0]  cat;
    logic [7:0]  op;
    logic [31:0] a, b;
    logic        we_in;
    logic [4:0]  addr;
    logic [31:0] hi, lo, mem_hi, mem_lo, wb_hi, wb_lo;
    logic        mem_we, wb_we;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        hwe;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
  } out_t;

  localparam longint INT_MAX = 64'sh7FFFFFFF;
  localparam longint INT_MIN = -64'sh80000000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stage_ex_if bus();
  stage_ex dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [10:0] valid_ops [20] = '{
    {CAT_LOGIC, OP_AND}, {CAT_LOGIC, OP_OR}, {CAT_LOGIC, OP_XOR}, {CAT_LOGIC, OP_NOR},
    {CAT_SHIFT, OP_SLL}, {CAT_SHIFT, OP_SRL}, {CAT_SHIFT, OP_SRA},
    {CAT_MOVE, OP_MFHI}, {CAT_MOVE, OP_MFLO}, {CAT_MOVE, OP_MTHI}, {CAT_MOVE, OP_MTLO},
    {CAT_ARITH, OP_ADD}, {CAT_ARITH, OP_ADDU}, {CAT_ARITH, OP_SUB}, {CAT_ARITH, OP_SUBU},
    {CAT_ARITH, OP_SLT}, {CAT_ARITH, OP_SLTU},
    {CAT_MULDIV, OP_MULT}, {CAT_MULDIV, OP_MULTU}, {CAT_NOP, 8'h00}
  };

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic stim_t blank();
    stim_t s;
    s.cat = '0; s.op = '0; s.a = '0; s.b = '0; s.we_in = 1'b0; s.addr = '0;
    s.hi = '0; s.lo = '0; s.mem_hi = '0; s.mem_lo = '0; s.wb_hi = '0; s.wb_lo = '0;
    s.mem_we = 1'b0; s.wb_we = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.category = s.cat; bus.operator = s.op;
    bus.operand_a = s.a; bus.operand_b = s.b;
    bus.register_write_enable_in = s.we_in; bus.register_write_address_in = s.addr;
    bus.hi = s.hi; bus.lo = s.lo;
    bus.mem_hilo_write_enable = s.mem_we; bus.mem_hi = s.mem_hi; bus.mem_lo = s.mem_lo;
    bus.wb_hilo_write_enable = s.wb_we; bus.wb_hi = s.wb_hi; bus.wb_lo = s.wb_lo;
  endtask

  task automatic observe(output out_t o);
    o.we = bus.register_write_enable; o.addr = bus.register_write_address;
    o.data = bus.register_write_data; o.hwe = bus.hilo_write_enable;
    o.hi = bus.hi_write_data; o.lo = bus.lo_write_data; o.stall = bus.stall_request;
  endtask

  // Reference for all single-cycle operations, from the arithmetic meaning of each op
  function automatic out_t model(input stim_t s);
    out_t o;
    logic known;
    longint sa, sb, r;
    logic [63:0] p;
    logic [31:0] eh, el;
    int sh;
    o = '0;
    known = 1'b1;
    eh = s.mem_we ? s.mem_hi : (s.wb_we ? s.wb_hi : s.hi);
    el = s.mem_we ? s.mem_lo : (s.wb_we ? s.wb_lo : s.lo);
    sa = longint'($signed(s.a));
    sb = longint'($signed(s.b));
    sh = int'(s.a[4:0]);
    o.we = s.we_in;
    case (s.cat)
      CAT_NOP: ;
      CAT_LOGIC: case (s.op)
        OP_AND: o.data = s.a & s.b;
        OP_OR:  o.data = s.a | s.b;
        OP_XOR: o.data = s.a ^ s.b;
        OP_NOR: o.data = ~(s.a | s.b);
        default: known = 1'b0;
      endcase
      CAT_SHIFT: case (s.op)
        OP_SLL: o.data = 32'(longint'(s.b) * (longint'(1) << sh));
        OP_SRL: o.data = 32'(longint'(s.b) >> sh);
        OP_SRA: o.data = 32'(sb >>> sh);
        default: known = 1'b0;
      endcase
      CAT_MOVE: case (s.op)
        OP_MFHI: o.data = eh;
        OP_MFLO: o.data = el;
        OP_MTHI: begin o.hwe = 1'b1; o.hi = s.a; o.lo = el; end
        OP_MTLO: begin o.hwe = 1'b1; o.hi = eh; o.lo = s.a; end
        default: known = 1'b0;
      endcase
      CAT_ARITH: case (s.op)
        OP_ADD:  begin r = sa + sb; o.data = 32'(r); if (r > INT_MAX || r < INT_MIN) o.we = 1'b0; end
        OP_ADDU: o.data = 32'(sa + sb);
        OP_SUB:  begin r = sa - sb; o.data = 32'(r); if (r > INT_MAX || r < INT_MIN) o.we = 1'b0; end
        OP_SUBU: o.data = 32'(sa - sb);
        OP_SLT:  o.data = (sa < sb) ? 32'd1 : 32'd0;
        OP_SLTU: o.data = (longint'(s.a) < longint'(s.b)) ? 32'd1 : 32'd0;
        default: known = 1'b0;
      endcase
      CAT_MULDIV: begin
        o.we = 1'b0;
        case (s.op)
          OP_MULT:  begin p = 64'(sa * sb); o.hwe = 1'b1; o.hi = p[63:32]; o.lo = p[31:0]; end
          OP_MULTU: begin p = 64'(longint'(s.a) * longint'(s.b)); o.hwe = 1'b1; o.hi = p[63:32]; o.lo = p[31:0]; end
          default: known = 1'b0;
        endcase
      end
      default: known = 1'b0;
    endcase
    if (!known) o = '0;
    o.addr = s.addr;
    return o;
  endfunction

  task automatic run_single(input stim_t s, output out_t o);
    @(posedge clock); #1;
    apply(s);
    @(negedge clock);
    observe(o);
  endtask

  task automatic compare_out(input string tag, input out_t got, input out_t want);
    check({tag, ".we"}, got.we, want.we);
    check({tag, ".addr"}, got.addr, want.addr);
    check({tag, ".data"}, got.data, want.data);
    check({tag, ".hwe"}, got.hwe, want.hwe);
    check({tag, ".hi"}, got.hi, want.hi);
    check({tag, ".lo"}, got.lo, want.lo);
    check({tag, ".stall"}, got.stall, want.stall);
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
    stim_t s;
    out_t o;
    int n;
    logic early;
    longint q, r;
    logic [31:0] eh, el;
    s = blank();
    s.cat = CAT_MULDIV; s.op = sgn ? OP_DIV : OP_DIVU; s.a = a; s.b = b;
    s.we_in = 1'b1; s.addr = 5'd9;
    if (b == 32'd0) begin
      eh = '0; el = '0;
    end else begin
      if (sgn) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
      end else begin
        q = longint'(a) / longint'(b);
        r = longint'(a) % longint'(b);
      end
      eh = 32'(r); el = 32'(q);
    end
    n = 0;
    early = 1'b0;
    @(posedge clock); #1;
    apply(s);
    while (n <= 40) begin
      @(negedge clock);
      observe(o);
      if (!o.stall) break;
      if (o.hwe) early = 1'b1;
      n++;
      @(posedge clock); #1;
    end
    check({tag, ".stalls"}, n, (b == 32'd0) ? 1 : 33);
    check({tag, ".early_write"}, early, 1'b0);
    check({tag, ".hwe"}, o.hwe, 1'b1);
    check({tag, ".hi"}, o.hi, eh);
    check({tag, ".lo"}, o.lo, el);
    check({tag, ".we"}, o.we, 1'b0);
    @(posedge clock); #1;
    apply(blank());
    @(negedge clock);
    observe(o);
    check({tag, ".idle_stall"}, o.stall, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int k;
    s = blank();
    k = $urandom_range(0, 99);
    if (k < 85) begin
      {s.cat, s.op} = valid_ops[$urandom_range(0, 19)];
    end else if (k < 93) begin
      s.cat = 3'($urandom_range(6, 7));
      s.op = 8'($urandom);
    end else begin
      s.cat = CAT_MULDIV;
      s.op = 8'($urandom);
      if (s.op == OP_DIV || s.op == OP_DIVU) s.op = 8'hFF;
    end
    s.a = pick(); s.b = pick();
    s.we_in = 1'($urandom); s.addr = 5'($urandom);
    s.hi = $urandom; s.lo = $urandom;
    s.mem_hi = $urandom; s.mem_lo = $urandom; s.wb_hi = $urandom; s.wb_lo = $urandom;
    s.mem_we = 1'($urandom); s.wb_we = 1'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s;
    out_t o;
    int n;

    // Reset forces every output low even with a live instruction presented
    reset = 1'b1;
    s = blank();
    s.cat = CAT_LOGIC; s.op = OP_OR; s.a = 32'h0000F0F0; s.b = 32'h00000F0F;
    s.we_in = 1'b1; s.addr = 5'd5; s.hi = 32'h11111111; s.lo = 32'h22222222;
    apply(s);
    repeat (2) @(posedge clock);
    @(negedge clock);
    observe(o);
    check("reset_outputs", o, '0);
    @(posedge clock); #1;
    reset = 1'b0;

    // ORI
    run_single(s, o);
    check("ori.data", o.data, 32'h0000FFFF);
    check("ori.we", o.we, 1'b1);
    check("ori.addr", o.addr, 5'd5);
    check("ori.stall", o.stall, 1'b0);

    // ADD overflow vs ADDU wrap
    s = blank(); s.cat = CAT_ARITH; s.op = OP_ADD; s.a = 32'h7FFFFFFF; s.b = 32'd1;
    s.we_in = 1'b1; s.addr = 5'd3;
    run_single(s, o);
    check("add_ovf.we", o.we, 1'b0);
    s.op = OP_ADDU;
    run_single(s, o);
    check("addu.data", o.data, 32'h80000000);
    check("addu.we", o.we, 1'b1);
    s.op = OP_SUB; s.a = 32'h80000000; s.b = 32'd1;
    run_single(s, o);
    check("sub_ovf.we", o.we, 1'b0);

    // MULT -3 * 5
    s = blank(); s.cat = CAT_MULDIV; s.op = OP_MULT; s.a = 32'hFFFFFFFD; s.b = 32'd5;
    run_single(s, o);
    check("mult.hi", o.hi, 32'hFFFFFFFF);
    check("mult.lo", o.lo, 32'hFFFFFFF1);
    check("mult.hwe", o.hwe, 1'b1);

    // HI/LO forwarding priority
    s = blank(); s.cat = CAT_MOVE; s.op = OP_MFHI; s.we_in = 1'b1; s.addr = 5'd7;
    s.mem_we = 1'b1; s.mem_hi = 32'h12345678; s.wb_we = 1'b1; s.wb_hi = 32'hAAAAAAAA; s.hi = 32'h0;
    run_single(s, o);
    check("mfhi_mem.data", o.data, 32'h12345678);
    s.op = OP_MFLO; s.mem_we = 1'b0; s.wb_lo = 32'h0BADF00D; s.lo = 32'h55555555;
    run_single(s, o);
    check("mflo_wb.data", o.data, 32'h0BADF00D);

    // Divides
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, "div_m7_2");
    do_div(32'd7, 32'd0, 1'b0, "divu_7_0");

    // Reset in the middle of a divide
    s = blank(); s.cat = CAT_MULDIV; s.op = OP_DIV; s.a = 32'hFFFFFFF9; s.b = 32'd2;
    @(posedge clock); #1;
    apply(s);
    n = 0;
    while (n < 9) begin
      @(posedge clock); #1;
      n++;
    end
    reset = 1'b1;
    @(negedge clock);
    observe(o);
    check("rst_mid.outputs", o, '0);
    @(posedge clock); #1;
    reset = 1'b0;
    apply(blank());
    @(negedge clock);
    observe(o);
    check("rst_after.stall", o.stall, 1'b0);
    check("rst_after.outputs", o, '0);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, "div_after_rst");

    // Random single-cycle operations
    for (int i = 0; i < 300; i++) begin
      s = rand_stim();
      run_single(s, o);
      compare_out($sformatf("rnd%0d", i), o, model(s));
    end

    // Random divides
    for (int j = 0; j < 6; j++) begin
      do_div(pick(), (j == 0) ? 32'd0 : pick(), 1'($urandom), $sformatf("rdiv%0d", j));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
